prime_scanner: RTL and testbench
================================

Name: prime_scanner

Overview:
- Sequential candidate generator that sits directly upstream of the team's 4-bit combinational prime detector.
- On `start`, sweeps a 4-bit candidate from `lo` to `hi` inclusive, one candidate per cycle, and drives it to the detector.
- Samples the detector's `isprime` result in the same cycle.
- Streams each prime candidate out over a valid/ready handshake and reports the number of primes found and completion.

Parameters:
- None. The width is fixed at 4 bits to match the detector; 1 is treated as prime, consistent with the detector.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin scan; sampled only in IDLE
- lo  input  4  first candidate; sampled with start
- hi  input  4  last candidate, inclusive; sampled with start
- cand  output  4  current candidate, to the detector `in`
- isprime  input  1  detector result for `cand`, same cycle (combinational return path)
- out_valid  output  1  `out_data` holds a prime
- out_ready  input  1  downstream accepts `out_data`
- out_data  output  4  prime value being offered
- prime_count  output  4  primes emitted in the current/last scan
- busy  output  1  scan in progress (SCAN or HOLD)
- done  output  1  one-cycle pulse at scan end
- range_err  output  1  last start had lo > hi; held until next accepted start

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE
  - cand, out_data, prime_count = 0
  - out_valid, busy, done, range_err = 0
- Reset mid-scan aborts immediately to these values; no done pulse.
- All outputs are registered.
- Clock and reset ports are `clk` and `reset`: one clock; reset is synchronous and active-high.
- FSM states: IDLE, SCAN, HOLD, DONE.
- IDLE:
  - start=1 and lo<=hi: cand<=lo, `lo`/`hi` latched internally (hi_r), prime_count<=0, range_err<=0, go to SCAN.
  - start=1 and lo>hi: range_err<=1, prime_count<=0, go to DONE.
- SCAN (busy=1), isprime is evaluated for `cand`:
  - isprime=1: out_data<=cand, out_valid<=1, prime_count<=prime_count+1, go to HOLD; cand is not advanced.
  - isprime=0 and cand==hi_r: go to DONE.
  - isprime=0 otherwise: cand<=cand+1, stay in SCAN.
- HOLD (busy=1, out_valid=1):
  - out_data and cand stay stable until out_ready=1.
  - On the handshake cycle (out_valid & out_ready): out_valid<=0; if cand==hi_r go to DONE, else cand<=cand+1 and go to SCAN.
  - out_valid never drops without a handshake.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. prime_count and range_err hold afterwards.
- No wrap-around: the end test (cand==hi_r) is made before incrementing, so hi=15 never increments cand to 0.
- start while busy or in DONE is ignored; `lo`/`hi` changes during a scan have no effect.
- Per-candidate cost: non-prime = 1 cycle; prime = 2 cycles minimum (SCAN + HOLD with out_ready=1), plus one cycle per extra backpressure cycle.
- Latency: start sampled at edge 0 → first cand valid in cycle 1 → first out_valid no earlier than cycle 2.
- prime_count maximum is 7 (range 0..15: 1,2,3,5,7,11,13); 4 bits is sufficient, no saturation logic required.

Test Plan:
- Full range: lo=0, hi=15, out_ready=1 → out_data sequence 1,2,3,5,7,11,13; prime_count=7; done pulses exactly 24 cycles after the start edge; busy high for cycles 1..23.
- Backpressure: lo=2, hi=3, out_ready low 3 cycles during the first HOLD → out_data=2 with out_valid stable for 4 cycles, then 3; no value lost or duplicated; prime_count=2.
- No primes / single point: lo=hi=8 → no out_valid, done on cycle 2, prime_count=0. lo=hi=13 → single output 13, prime_count=1.
- Range error: lo=9, hi=4 → range_err=1, done pulse on cycle 1, no out_valid, busy never asserted.
- Upper boundary: lo=14, hi=15 → cand steps 14 then 15 and never shows 0; no outputs; done on cycle 3.
- Reset and ignored start: start pulsed again mid-scan → no effect on the sequence. reset asserted while in HOLD → next cycle all outputs 0, state IDLE, no done pulse. A following start scans normally.

Source files
------------

// File: rtl/prime_scanner.sv
// prime_scanner: sweeps a 4-bit candidate range through the external combinational
// prime detector and streams each prime out over a valid/ready handshake.

module prime_scanner_checker (
    input logic       clk,
    input logic       reset,
    input logic       out_valid,
    input logic       out_ready,
    input logic [3:0] out_data,
    input logic       busy,
    input logic       done
);
    // An offered prime persists, unchanged, until the consumer takes it.
    a_offer_held: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_done_pulse: assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

    a_done_quiet: assert property (@(posedge clk) disable iff (reset)
        done |-> (!busy && !out_valid));

    a_valid_busy: assert property (@(posedge clk) disable iff (reset)
        out_valid |-> busy);
endmodule

module prime_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    output logic [3:0] cand,
    input  logic       isprime,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [3:0] prime_count,
    output logic       busy,
    output logic       done,
    output logic       range_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_r;
    logic [3:0] hi_r;
    logic       last_cand_s;

    // End test is made on the current candidate, so hi=15 never wraps cand to 0.
    assign last_cand_s = (cand == hi_r);

    // Scan controller; every output is a register written only here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            hi_r        <= 4'd0;
            cand        <= 4'd0;
            out_data    <= 4'd0;
            prime_count <= 4'd0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        prime_count <= 4'd0;
                        if (lo <= hi) begin
                            cand      <= lo;
                            hi_r      <= hi;
                            range_err <= 1'b0;
                            busy      <= 1'b1;
                            state_r   <= SCAN;
                        end else begin
                            range_err <= 1'b1;
                            done      <= 1'b1;
                            state_r   <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (isprime) begin
                        out_data    <= cand;
                        out_valid   <= 1'b1;
                        prime_count <= prime_count + 4'd1;
                        state_r     <= HOLD;
                    end else if (last_cand_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cand <= cand + 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_cand_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            cand    <= cand + 4'd1;
                            state_r <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    prime_scanner_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );
endmodule

// File: tb/tb_prime_scanner.sv
// Bench for prime_scanner: a transaction-level model predicts the prime stream,
// count and scan length; a negedge monitor compares the DUT against it every cycle.

module tb_prime_scanner;
    logic       clk = 1'b0;
    logic       reset, start, isprime, out_valid, out_ready, busy, done, range_err;
    logic [3:0] lo, hi, cand, out_data, prime_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit   model_idle   = 1'b1;
    bit   idle_pending = 1'b0;
    bit   expect_zero  = 1'b0;
    bit   exp_rerr     = 1'b0;
    int   exp_q[$];
    int   exp_cnt = 0;
    int   lo_m, hi_m, start_c, rel, valid_cycles, n_popped, cur_run, last_cand;
    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b0;
    logic [3:0] prev_data;

    int   emitted[$];
    int   runs[$];
    int   cand_trace[$];
    int   last_len = 0;
    int   busy_cnt = 0;
    int   full_primes[7] = '{1, 2, 3, 5, 7, 11, 13};

    prime_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .cand        (cand),
        .isprime     (isprime),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .prime_count (prime_count),
        .busy        (busy),
        .done        (done),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_prime_f(input int n);
        if (n == 1) return 1'b1;
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Stand-in for the combinational detector on the cand -> isprime path.
    assign isprime = is_prime_f(int'(cand));

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the transaction model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (expect_zero) begin
                check("reset_cand", 32'(cand), 32'd0);
                check("reset_out_data", 32'(out_data), 32'd0);
                check("reset_count", 32'(prime_count), 32'd0);
                check("reset_valid", 32'(out_valid), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                check("reset_range_err", 32'(range_err), 32'd0);
                expect_zero = 1'b0;
            end
            if (reset === 1'b1) begin
                expect_zero  = 1'b1;
                model_idle   = 1'b1;
                idle_pending = 1'b0;
                exp_q.delete();
                exp_cnt      = 0;
                exp_rerr     = 1'b0;
                prev_valid   = 1'b0;
            end else begin
                if (idle_pending) begin
                    model_idle   = 1'b1;
                    idle_pending = 1'b0;
                end
                if (model_idle) begin
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_done", 32'(done), 32'd0);
                    check("idle_valid", 32'(out_valid), 32'd0);
                    check("idle_count", 32'(prime_count), 32'(exp_cnt));
                    check("idle_range_err", 32'(range_err), 32'(exp_rerr));
                    if (start === 1'b1) begin
                        lo_m       = int'(lo);
                        hi_m       = int'(hi);
                        start_c    = cyc;
                        model_idle = 1'b0;
                        exp_rerr   = (lo_m > hi_m);
                        exp_q.delete();
                        if (!exp_rerr)
                            for (int v = lo_m; v <= hi_m; v++)
                                if (is_prime_f(v)) exp_q.push_back(v);
                        exp_cnt      = exp_q.size();
                        valid_cycles = 0;
                        n_popped     = 0;
                        cur_run      = 0;
                        last_cand    = -1;
                        busy_cnt     = 0;
                        emitted.delete();
                        runs.delete();
                        cand_trace.delete();
                    end
                end else begin
                    rel = cyc - start_c;
                    check("count_tracks_emitted", 32'(prime_count), 32'(n_popped + (out_valid === 1'b1 ? 1 : 0)));
                    if (prev_valid && !prev_ready) begin
                        check("valid_held", 32'(out_valid), 32'd1);
                        check("data_held", 32'(out_data), 32'(prev_data));
                    end
                    if (out_valid === 1'b1) begin
                        valid_cycles++;
                        cur_run++;
                        check("data_is_cand", 32'(out_data), 32'(cand));
                        check("prime_pending", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
                        if (out_ready === 1'b1) begin
                            emitted.push_back(int'(out_data));
                            runs.push_back(cur_run);
                            cur_run = 0;
                            n_popped++;
                            if (exp_q.size() > 0) void'(exp_q.pop_front());
                        end
                    end
                    if (done === 1'b1) begin
                        check("done_busy", 32'(busy), 32'd0);
                        check("done_valid", 32'(out_valid), 32'd0);
                        check("done_left_over", 32'(exp_q.size()), 32'd0);
                        check("done_count", 32'(prime_count), 32'(exp_cnt));
                        check("done_range_err", 32'(range_err), 32'(exp_rerr));
                        check("done_cycle", 32'(rel),
                              32'(exp_rerr ? 1 : (hi_m - lo_m + 1) + valid_cycles + 1));
                        last_len     = rel;
                        idle_pending = 1'b1;
                    end else begin
                        check("scan_busy", 32'(busy), 32'(!exp_rerr));
                        check("scan_range_err", 32'(range_err), 32'd0);
                        if (busy === 1'b1) busy_cnt++;
                        if (!exp_rerr) begin
                            check("cand_in_range", 32'((int'(cand) >= lo_m) && (int'(cand) <= hi_m)), 32'd1);
                            check("cand_step", 32'((last_cand < 0) ? (int'(cand) == lo_m)
                                  : (int'(cand) == last_cand || int'(cand) == last_cand + 1)), 32'd1);
                            if (int'(cand) != last_cand) cand_trace.push_back(int'(cand));
                            last_cand = int'(cand);
                        end
                    end
                end
                prev_valid = (out_valid === 1'b1);
                prev_ready = (out_ready === 1'b1);
                prev_data  = out_data;
            end
        end
    end

    // mode 0: always ready, 1: random ready, 2: three stall cycles on the first offer.
    task automatic do_scan(input logic [3:0] l, input logic [3:0] h, input int mode, input bit noise);
        int n;
        int stalls;
        lo = l;
        hi = h;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lo = 4'($urandom);
        hi = 4'($urandom);
        n = 0;
        stalls = 0;
        while (done !== 1'b1 && n < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid === 1'b1 && stalls < 3) begin
                        out_ready = 1'b0;
                        stalls++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                lo = 4'($urandom);
                hi = 4'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        lo = 4'd0;
        hi = 4'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Full range with stray start pulses that must be ignored.
        do_scan(4'd0, 4'd15, 0, 1'b1);
        check("full_len", 32'(last_len), 32'd24);
        check("full_count", 32'(prime_count), 32'd7);
        check("full_busy_cycles", 32'(busy_cnt), 32'd23);
        check("full_n", 32'(emitted.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("full_seq", 32'(q_at(emitted, i)), 32'(full_primes[i]));

        do_scan(4'd2, 4'd3, 2, 1'b0);
        check("bp_first", 32'(q_at(emitted, 0)), 32'd2);
        check("bp_second", 32'(q_at(emitted, 1)), 32'd3);
        check("bp_n", 32'(emitted.size()), 32'd2);
        check("bp_hold_len", 32'(q_at(runs, 0)), 32'd4);
        check("bp_count", 32'(prime_count), 32'd2);
        check("bp_len", 32'(last_len), 32'd8);

        do_scan(4'd8, 4'd8, 0, 1'b0);
        check("single8_len", 32'(last_len), 32'd2);
        check("single8_n", 32'(emitted.size()), 32'd0);
        check("single8_count", 32'(prime_count), 32'd0);

        do_scan(4'd13, 4'd13, 0, 1'b0);
        check("single13_val", 32'(q_at(emitted, 0)), 32'd13);
        check("single13_n", 32'(emitted.size()), 32'd1);
        check("single13_count", 32'(prime_count), 32'd1);

        // Range error; start stays high through the DONE cycle and must be ignored.
        lo = 4'd9;
        hi = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        check("rerr_done", 32'(done), 32'd1);
        lo = 4'd2;
        hi = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("rerr_flag", 32'(range_err), 32'd1);
        check("rerr_len", 32'(last_len), 32'd1);
        check("rerr_busy_cycles", 32'(busy_cnt), 32'd0);
        check("rerr_n", 32'(emitted.size()), 32'd0);
        @(posedge clk); #1;

        do_scan(4'd14, 4'd15, 0, 1'b0);
        check("top_len", 32'(last_len), 32'd3);
        check("top_trace_n", 32'(cand_trace.size()), 32'd2);
        check("top_trace0", 32'(q_at(cand_trace, 0)), 32'd14);
        check("top_trace1", 32'(q_at(cand_trace, 1)), 32'd15);
        check("top_n", 32'(emitted.size()), 32'd0);

        // Reset while an offer is pending in HOLD.
        lo = 4'd0;
        hi = 4'd15;
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_reached", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cand", 32'(cand), 32'd0);
        check("abort_count", 32'(prime_count), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end

        do_scan(4'd0, 4'd15, 1, 1'b1);
        check("after_reset_count", 32'(prime_count), 32'd7);

        for (int k = 0; k < 30; k++)
            do_scan(4'($urandom), 4'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
